inst_encoder: RTL

//  Packs decoded fields plus a 64-bit byte immediate into a 32-bit RV64 instruction word.
//  It is the inverse of the datapath immediate generator.
//  It sits between the debug/boot program injector and instruction memory.
//  It emits (address, word) beats over a valid/ready stream with a 2-entry output buffer.

---
 rtl/inst_enc_pkg.sv | 41 ++++
 rtl/inst_enc_chk.sv | 48 ++++
 rtl/inst_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/inst_enc_pkg.sv
// Shared encodings for the RV64 instruction packer: format codes, opcodes, immediate range widths.
package inst_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  localparam int IMM_W_IS = 12;
  localparam int IMM_W_B  = 13;
  localparam int IMM_W_J  = 21;
  localparam int IMM_W_U  = 32;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic        mism;
  } enc_t;

  // True when v is the sign extension of its low w bits.
  function automatic logic fits_sext(input logic [63:0] v, input int w);
    logic [63:0] hi;
    hi = $signed(v) >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_enc_chk.sv
// Round-trip checker: decodes a packed word back to its immediate and flags disagreement.
// Present only when INST_ENC_CHECK_EN is defined.
`ifdef INST_ENC_CHECK_EN
module inst_enc_chk
  import inst_enc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:7] i_inst,
  input  logic [63:0] i_imm,
  input  logic        i_err,
  output logic        o_mism
);

  logic [63:0] w_dec;
  logic        w_chk;

  always_comb begin
    w_dec = '0;
    w_chk = 1'b0;
    case (i_fmt)
      FMT_I: begin
        w_dec = 64'($signed(i_inst[31:20]));
        w_chk = 1'b1;
      end
      FMT_S: begin
        w_dec = 64'($signed({i_inst[31:25], i_inst[11:7]}));
        w_chk = 1'b1;
      end
      // B and J decode to halfword units; restore the byte offset.
      FMT_B: begin
        w_dec = 64'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]})) << 1;
        w_chk = 1'b1;
      end
      FMT_U: begin
        w_dec = 64'($signed({i_inst[31:12], 12'h000}));
        w_chk = 1'b1;
      end
      FMT_J: begin
        w_dec = 64'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]})) << 1;
        w_chk = 1'b1;
      end
      default: ;
    endcase
    o_mism = w_chk & ~i_err & (w_dec != i_imm);
  end

endmodule
`endif

// File: rtl/inst_encoder.sv
// Packs decoded fields + byte immediate into an RV64 word; emits (addr, word) beats via a 2-entry buffer.
// Define INST_ENC_CHECK_EN to add the round-trip checker driving out_mism (tied to 0 otherwise).
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_fmt,
  input  logic [6:0]          req_opcode,
  input  logic [4:0]          req_rd,
  input  logic [4:0]          req_rs1,
  input  logic [4:0]          req_rs2,
  input  logic [2:0]          req_funct3,
  input  logic [6:0]          req_funct7,
  input  logic [63:0]         req_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic                out_mism,
  output logic [ERRCNT_W-1:0] err_cnt
);

  logic [31:0] w_raw;
  logic        w_ok;
  logic        w_mism;
  enc_t        w_enc;
  logic        w_push, w_pop;

  enc_t                r_head, r_skid;
  logic [ADDR_W-1:0]   r_head_addr, r_skid_addr, r_addr;
  logic                r_hv, r_sv;
  logic [ERRCNT_W-1:0] r_errcnt;

  always_comb begin
    w_raw = NOP_INST;
    w_ok  = 1'b0;
    case (req_fmt)
      FMT_R: begin
        w_raw = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
        w_ok  = 1'b1;
      end
      FMT_I: begin
        w_raw = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        w_ok  = fits_sext(req_imm, IMM_W_IS);
      end
      FMT_S: begin
        w_raw = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
        w_ok  = fits_sext(req_imm, IMM_W_IS);
      end
      FMT_B: begin
        w_raw = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                 req_imm[4:1], req_imm[11], req_opcode};
        w_ok  = ~req_imm[0] & fits_sext(req_imm, IMM_W_B);
      end
      FMT_U: begin
        w_raw = {req_imm[31:12], req_rd, req_opcode};
        w_ok  = (req_imm[11:0] == 12'h000) & fits_sext(req_imm, IMM_W_U);
      end
      FMT_J: begin
        w_raw = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
        w_ok  = ~req_imm[0] & fits_sext(req_imm, IMM_W_J);
      end
      default: ;
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  inst_enc_chk u_chk (
    .i_fmt  (req_fmt),
    .i_inst (w_raw[31:7]),
    .i_imm  (req_imm),
    .i_err  (~w_ok),
    .o_mism (w_mism)
  );
`else
  assign w_mism = 1'b0;
`endif

  assign w_enc.inst = w_ok ? w_raw : NOP_INST;
  assign w_enc.err  = ~w_ok;
  assign w_enc.mism = w_mism;

  // Ready only from registered occupancy, so it never depends on out_ready.
  assign req_ready = ~rst & ~r_sv;
  assign w_push    = req_valid & req_ready;
  assign w_pop     = r_hv & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hv        <= 1'b0;
      r_sv        <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
      r_head_addr <= BASE_ADDR;
      r_skid_addr <= BASE_ADDR;
      r_addr      <= BASE_ADDR;
      r_errcnt    <= '0;
    end else begin
      if (w_push) r_addr <= r_addr + ADDR_W'(4);
      if (w_pop && r_head.err && (r_errcnt != '1)) r_errcnt <= r_errcnt + ERRCNT_W'(1);
      case ({w_push, w_pop})
        // push implies the skid is empty, so the new beat goes straight to head
        2'b11: begin
          r_head      <= w_enc;
          r_head_addr <= r_addr;
        end
        2'b10: begin
          if (!r_hv) begin
            r_head      <= w_enc;
            r_head_addr <= r_addr;
            r_hv        <= 1'b1;
          end else begin
            r_skid      <= w_enc;
            r_skid_addr <= r_addr;
            r_sv        <= 1'b1;
          end
        end
        2'b01: begin
          if (r_sv) begin
            r_head      <= r_skid;
            r_head_addr <= r_skid_addr;
            r_sv        <= 1'b0;
          end else begin
            r_hv <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_hv;
  assign out_inst  = r_head.inst;
  assign out_addr  = r_head_addr;
  assign out_err   = r_head.err;
  assign out_mism  = r_head.mism;
  assign err_cnt   = r_errcnt;

endmodule
